// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result buffers arbitrated round-robin onto CDB_PORTS registered broadcast ports.
// Define CDB_ARB_BYPASS_EN to let an empty buffer's incoming result compete in the handshake cycle.
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int CDB_PORTS = 2,
  parameter int PHYS_BITS = 6,
  parameter int ROB_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NUM_FU-1:0]     fu_valid,
  output logic [NUM_FU-1:0]     fu_ready,
  input  logic [PHYS_BITS-1:0]  fu_pd    [NUM_FU],
  input  logic [31:0]           fu_data  [NUM_FU],
  input  logic [ROB_BITS-1:0]   fu_rob   [NUM_FU],
  output logic [CDB_PORTS-1:0]  cdb_valid,
  output logic [PHYS_BITS-1:0]  cdb_pd   [CDB_PORTS],
  output logic [31:0]           cdb_data [CDB_PORTS],
  output logic [ROB_BITS-1:0]   cdb_rob  [CDB_PORTS]
);
  localparam int PW = NUM_FU > 1 ? $clog2(NUM_FU) : 1;
  logic [NUM_FU-1:0]    r_full, w_cand, w_grant, w_byp, w_load;
  logic [PHYS_BITS-1:0] r_pd   [NUM_FU];
  logic [31:0]          r_data [NUM_FU];
  logic [ROB_BITS-1:0]  r_rob  [NUM_FU];
  logic [PW-1:0]        r_ptr, w_ptr_nxt, w_idx;
  logic [CDB_PORTS-1:0] w_cv;
  logic [PHYS_BITS-1:0] w_cpd   [CDB_PORTS];
  logic [31:0]          w_cdata [CDB_PORTS];
  logic [ROB_BITS-1:0]  w_crob  [CDB_PORTS];
`ifdef CDB_ARB_BYPASS_EN
  assign w_byp = ~r_full & fu_valid & {NUM_FU{~flush}};
`else
  assign w_byp = '0;
`endif
  assign w_cand   = r_full | w_byp;
  assign fu_ready = {NUM_FU{~flush}} & (~r_full | (w_grant & r_full));
  assign w_load   = fu_valid & fu_ready & ~(w_byp & w_grant);
  // Port k takes the k-th candidate in scan order starting at r_ptr.
  always_comb begin
    w_grant   = '0;
    w_cv      = '0;
    w_ptr_nxt = r_ptr;
    w_idx     = '0;
    for (int k = 0; k < CDB_PORTS; k++) begin
      w_cpd[k]   = '0;
      w_cdata[k] = '0;
      w_crob[k]  = '0;
      for (int j = 0; j < NUM_FU; j++) begin
        w_idx = PW'((int'(r_ptr) + j) % NUM_FU);
        if (!w_cv[k] && w_cand[w_idx] && !w_grant[w_idx]) begin
          w_cv[k]        = 1'b1;
          w_grant[w_idx] = 1'b1;
          w_cpd[k]       = r_full[w_idx] ? r_pd[w_idx]   : fu_pd[w_idx];
          w_cdata[k]     = r_full[w_idx] ? r_data[w_idx] : fu_data[w_idx];
          w_crob[k]      = r_full[w_idx] ? r_rob[w_idx]  : fu_rob[w_idx];
          w_ptr_nxt      = PW'((int'(w_idx) + 1) % NUM_FU);
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_ptr     <= '0;
      cdb_valid <= '0;
      for (int k = 0; k < CDB_PORTS; k++) begin
        cdb_pd[k]   <= '0;
        cdb_data[k] <= '0;
        cdb_rob[k]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (flush) r_full[i] <= 1'b0;
        else if (w_load[i]) begin
          r_full[i] <= 1'b1;
          r_pd[i]   <= fu_pd[i];
          r_data[i] <= fu_data[i];
          r_rob[i]  <= fu_rob[i];
        end else if (w_grant[i]) r_full[i] <= 1'b0;
      end
      cdb_valid <= flush ? '0 : w_cv;
      if (!flush) begin
        r_ptr <= w_ptr_nxt;
        for (int k = 0; k < CDB_PORTS; k++) begin
          cdb_pd[k]   <= w_cpd[k];
          cdb_data[k] <= w_cdata[k];
          cdb_rob[k]  <= w_crob[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a cycle-stamped expected-broadcast queue checked by a CDB monitor.
module tb_cdb_arbiter;
  logic       clk = 0, rst = 1, flush = 0;
  logic [3:0] fu_valid = '0;
  logic [3:0] fu_ready;
  logic [5:0] fu_pd [4];
  logic [31:0] fu_data [4];
  logic [4:0] fu_rob [4];
  logic [1:0] cdb_valid;
  logic [5:0] cdb_pd [2];
  logic [31:0] cdb_data [2];
  logic [4:0] cdb_rob [2];
  int total = 0, bad = 0, cyc = 0, t0;
  typedef struct {int c; int port; logic [5:0] pd; logic [31:0] data; logic [4:0] rob;} exp_t;
  exp_t q[$];
  exp_t m;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_pd(fu_pd), .fu_data(fu_data), .fu_rob(fu_rob),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_data(cdb_data), .cdb_rob(cdb_rob)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c < cyc) begin
      total++; bad++;
      $display("FAIL missing_bcast cyc=%0d want port%0d pd=%0h data=%0h rob=%0h at cyc %0d",
               cyc, q[0].port, q[0].pd, q[0].data, q[0].rob, q[0].c);
      void'(q.pop_front());
    end
    for (int k = 0; k < 2; k++) if (cdb_valid[k]) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_bcast cyc=%0d port%0d got pd=%0h data=%0h rob=%0h want none",
                 cyc, k, cdb_pd[k], cdb_data[k], cdb_rob[k]);
      end else begin
        m = q.pop_front();
        if (m.c != cyc || m.port != k || m.pd !== cdb_pd[k] || m.data !== cdb_data[k] || m.rob !== cdb_rob[k]) begin
          bad++;
          $display("FAIL bcast got cyc=%0d port%0d pd=%0h data=%0h rob=%0h want cyc=%0d port%0d pd=%0h data=%0h rob=%0h",
                   cyc, k, cdb_pd[k], cdb_data[k], cdb_rob[k], m.c, m.port, m.pd, m.data, m.rob);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input int port, input logic [5:0] pd, input logic [31:0] data, input logic [4:0] rob);
    q.push_back('{c, port, pd, data, rob});
  endtask

  task automatic push_t(input int c, input int port, input int fu, input int tag);
    push(c, port, 6'(tag * 4 + fu), 32'h5A00_0000 + 32'(tag * 256 + fu), 5'(tag + fu));
  endtask

  task automatic present(input int fu, input logic [5:0] pd, input logic [31:0] data, input logic [4:0] rob);
    fu_valid[fu] = 1'b1;
    fu_pd[fu] = pd;
    fu_data[fu] = data;
    fu_rob[fu] = rob;
  endtask

  task automatic present_t(input int fu, input int tag);
    present(fu, 6'(tag * 4 + fu), 32'h5A00_0000 + 32'(tag * 256 + fu), 5'(tag + fu));
  endtask

  task automatic advance(input logic chk, input logic [3:0] er);
    @(negedge clk);
    if (chk) check("ready", 64'(fu_ready), 64'(er));
    @(posedge clk); #1;
    fu_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; fu_valid = '0;
    idle(2);
    rst = 0;
    @(negedge clk);
    check("rst_valid", 64'(cdb_valid), 0);
    check("rst_pd", 64'({cdb_pd[0], cdb_pd[1]}), 0);
    check("rst_rob", 64'({cdb_rob[0], cdb_rob[1]}), 0);
    check("rst_data", {cdb_data[0], cdb_data[1]}, 0);
    check("rst_ready", 64'(fu_ready), 64'hF);
    @(posedge clk); #1;
  endtask

  int sent [4];
  logic [3:0] hs;

  initial begin
    for (int i = 0; i < 4; i++) begin fu_pd[i] = '0; fu_data[i] = '0; fu_rob[i] = '0; end
    // single result, two-edge latency
    do_reset(); t0 = cyc;
    present(0, 6'd5, 32'hDEADBEEF, 5'd3);
    push(t0 + 2, 0, 6'd5, 32'hDEADBEEF, 5'd3);
    advance(1, 4'hF);
    idle(3);
    // all FUs streaming: grants alternate {0,1},{2,3}
    do_reset(); t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      push_t(t0 + 2 + 2 * k, 0, 0, 10 + k);
      push_t(t0 + 2 + 2 * k, 1, 1, 10 + k);
      push_t(t0 + 3 + 2 * k, 0, 2, 10 + k);
      push_t(t0 + 3 + 2 * k, 1, 3, 10 + k);
    end
    for (int i = 0; i < 4; i++) sent[i] = 0;
    for (int e = 0; e < 10; e++) begin
      for (int i = 0; i < 4; i++) if (sent[i] < 4) present_t(i, 10 + sent[i]);
      @(negedge clk);
      if (e <= 6) check("rr_ready", 64'(fu_ready), e == 0 ? 64'hF : (e % 2 == 1 ? 64'h3 : 64'hC));
      hs = fu_valid & fu_ready;
      @(posedge clk); #1;
      fu_valid = '0;
      for (int i = 0; i < 4; i++) if (hs[i]) sent[i]++;
    end
    check("all_sent", 64'(sent[0] + sent[1] + sent[2] + sent[3]), 16);
    idle(2);
    // rr_ptr=2 with buffers 1,3 full, then 0,3 full
    do_reset(); t0 = cyc;
    present_t(0, 40); present_t(1, 40);
    push_t(t0 + 2, 0, 0, 40); push_t(t0 + 2, 1, 1, 40);
    advance(1, 4'hF);
    present_t(1, 41); present_t(3, 41);
    push_t(t0 + 3, 0, 3, 41); push_t(t0 + 3, 1, 1, 41);
    advance(1, 4'hF);
    present_t(0, 42); present_t(3, 42);
    push_t(t0 + 4, 0, 3, 42); push_t(t0 + 4, 1, 0, 42);
    advance(1, 4'hF);
    idle(3);
    // flush with all four buffers full
    do_reset(); t0 = cyc;
    for (int i = 0; i < 4; i++) present_t(i, 20);
    advance(1, 4'hF);
    flush = 1;
    advance(1, 4'h0);
    flush = 0;
    present_t(2, 21);
    push_t(t0 + 4, 0, 2, 21);
    @(negedge clk);
    check("flush_cdb", 64'(cdb_valid), 0);
    check("flush_ready", 64'(fu_ready), 64'hF);
    @(posedge clk); #1;
    fu_valid = '0;
    idle(3);
    // reset while results are buffered and on the bus
    do_reset(); t0 = cyc;
    present_t(0, 30);
    push_t(t0 + 2, 0, 0, 30);
    advance(1, 4'hF);
    for (int i = 1; i < 4; i++) present_t(i, 31);
    advance(1, 4'hF);
    rst = 1;
    present_t(0, 32);
    advance(0, 4'h0);
    rst = 0;
    @(negedge clk);
    check("rst2_valid", 64'(cdb_valid), 0);
    check("rst2_pd", 64'({cdb_pd[0], cdb_pd[1]}), 0);
    check("rst2_data", {cdb_data[0], cdb_data[1]}, 0);
    check("rst2_rob", 64'({cdb_rob[0], cdb_rob[1]}), 0);
    check("rst2_ready", 64'(fu_ready), 64'hF);
    @(posedge clk); #1;
    idle(4);
    // pd=0 still broadcast
    t0 = cyc;
    present(1, 6'd0, 32'd7, 5'd9);
    push(t0 + 2, 0, 6'd0, 32'd7, 5'd9);
    advance(1, 4'hF);
    idle(3);
    check("queue_empty", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit result sources.
REQ-002 Parameter CDB_PORTS, default 2: number of CDB broadcast ports (equals regfile write ports).
REQ-003 Parameter PHYS_BITS, default 6: physical register tag width.
REQ-004 Parameter ROB_BITS, default 5: ROB index width.
REQ-005 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port flush, input, 1: mispredict squash; discards all buffered and pending results.
REQ-008 Port fu_valid[NUM_FU], input, 1 each: FU i presents a result.
REQ-009 Port fu_ready[NUM_FU], output, 1 each: arbiter accepts FU i's result this cycle.
REQ-010 Port fu_pd[NUM_FU], input, PHYS_BITS each: destination physical register tag.
REQ-011 Port fu_data[NUM_FU], input, 32 each: result value.
REQ-012 Port fu_rob[NUM_FU], input, ROB_BITS each: ROB index of the producing instruction.
REQ-013 Port cdb_valid[CDB_PORTS], output, 1 each: broadcast port k carries a result.
REQ-014 Port cdb_pd[CDB_PORTS], output, PHYS_BITS each: broadcast destination tag.
REQ-015 Port cdb_data[CDB_PORTS], output, 32 each: broadcast value.
REQ-016 Port cdb_rob[CDB_PORTS], output, ROB_BITS each: broadcast ROB index.

Function
REQ-017 The block SHALL hold one single-entry result buffer (full bit, pd, data, rob) per FU.
REQ-018 fu_ready[i] SHALL be combinationally high iff flush is low and (buffer i is empty or buffer i is granted this cycle).
REQ-019 A handshake (fu_valid[i] && fu_ready[i]) SHALL load buffer i at the clock edge; a simultaneous grant and accept on the same FU SHALL leave buffer i full with the new result.
REQ-020 Each cycle, the block SHALL scan full buffers in order rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_FU, and grant the first min(CDB_PORTS, full count) of them.
REQ-021 The n-th granted buffer in scan order SHALL drive CDB port n; ungranted ports SHALL have cdb_valid low.
REQ-022 CDB outputs SHALL be registered: a grant at edge E makes cdb_valid/pd/data/rob visible for exactly the cycle after E.
REQ-023 A granted buffer SHALL clear at the same edge unless refilled per REQ-019.
REQ-024 rr_ptr SHALL advance to (last granted index + 1) mod NUM_FU when any grant occurs and SHALL hold otherwise.
REQ-025 Results with fu_pd = 0 SHALL be broadcast normally (ROB completion); suppressing the register write is the consumer's job.
REQ-026 No result SHALL be dropped, duplicated or reordered within one FU; an FU with a full, ungranted buffer SHALL see fu_ready low.
REQ-027 With flush high at edge E, all buffers SHALL clear, no grants SHALL take effect, and all cdb_valid SHALL be low in the cycle after E; rr_ptr SHALL hold.

Reset
REQ-028 When rst is high at a clock edge, all buffers SHALL clear, rr_ptr SHALL become 0, and all cdb_valid, cdb_pd, cdb_data and cdb_rob SHALL become 0.
REQ-029 rst SHALL take priority over flush and over any handshake in the same cycle; results in flight during reset SHALL be discarded.

Configuration
REQ-030 With macro CDB_ARB_BYPASS_EN defined, an FU whose buffer is empty SHALL have its incoming valid result arbitrated in the same cycle as the handshake (1-edge latency to cdb_valid), and its buffer SHALL load only if not granted.
REQ-031 With CDB_ARB_BYPASS_EN undefined, every result SHALL pass through its buffer (minimum 2 edges from handshake to cdb_valid).

Verification
REQ-032 After reset, FU0 sends pd=5, data=0xDEADBEEF, rob=3 -> cdb_valid[0]=1 with those values two cycles later (one with bypass); cdb_valid[1]=0.
REQ-033 All 4 FUs valid every cycle, CDB_PORTS=2 -> grants alternate {0,1},{2,3},{0,1}; each FU has fu_ready high every other cycle; no loss.
REQ-034 Buffers 1 and 3 full, rr_ptr=2 -> port0 carries FU3, port1 carries FU1; rr_ptr becomes 2.
REQ-035 Buffers 0..3 full, flush high for one cycle -> all cdb_valid low next cycle; a new FU2 result is broadcast on port0 afterward.
REQ-036 rst asserted while 3 buffers are full and cdb_valid[0]=1 -> all CDB outputs 0 next cycle; fu_ready all high once rst is low.
REQ-037 FU1 sends pd=0, data=7 -> broadcast on the CDB with cdb_pd=0, cdb_data=7.
